// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 shift-add multiplier / restoring divider that owns HI/LO and serves MFHI/MFLO/MTHI/MTLO.
// Optional build macro MULDIV_DIVZERO_EN adds o_divZero and a one-cycle divide-by-zero path.
module muldiv_sequencer #(
    parameter int N_BITS  = 32,
    parameter int N_FUNCT = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [N_FUNCT-1:0] i_funct,
    input  logic [N_BITS-1:0]  i_datoA,
    input  logic [N_BITS-1:0]  i_datoB,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_stall,
    output logic               o_done,
`ifdef MULDIV_DIVZERO_EN
    output logic               o_divZero,
`endif
    output logic [N_BITS-1:0]  o_result,
    output logic [N_BITS-1:0]  o_hi,
    output logic [N_BITS-1:0]  o_lo
);

    localparam int CNT_W = $clog2(N_BITS);

    localparam logic [N_FUNCT-1:0] F_MULT  = N_FUNCT'(6'b011000);
    localparam logic [N_FUNCT-1:0] F_MULTU = N_FUNCT'(6'b011001);
    localparam logic [N_FUNCT-1:0] F_DIV   = N_FUNCT'(6'b011010);
    localparam logic [N_FUNCT-1:0] F_DIVU  = N_FUNCT'(6'b011011);
    localparam logic [N_FUNCT-1:0] F_MFHI  = N_FUNCT'(6'b010000);
    localparam logic [N_FUNCT-1:0] F_MTHI  = N_FUNCT'(6'b010001);
    localparam logic [N_FUNCT-1:0] F_MFLO  = N_FUNCT'(6'b010010);
    localparam logic [N_FUNCT-1:0] F_MTLO  = N_FUNCT'(6'b010011);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic [N_BITS-1:0] neg_n(input logic [N_BITS-1:0] v);
        return ~v + {{(N_BITS-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [N_BITS-1:0] abs_n(input logic [N_BITS-1:0] v);
        return v[N_BITS-1] ? neg_n(v) : v;
    endfunction

    function automatic logic is_start(input logic [N_FUNCT-1:0] f);
        logic r;
        case (f)
            F_MULT, F_MULTU, F_DIV, F_DIVU: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_hilo(input logic [N_FUNCT-1:0] f);
        logic r;
        case (f)
            F_MULT, F_MULTU, F_DIV, F_DIVU,
            F_MFHI, F_MTHI, F_MFLO, F_MTLO: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    state_t              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [N_BITS-1:0]   acc_q;
    logic [N_BITS-1:0]   lo_reg_q;
    logic [N_BITS-1:0]   mcand_q;
    logic [N_BITS-1:0]   dividend_q;
    logic                is_div_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic                divzero_q;
    logic                busy_q;
    logic                done_q;
    logic [N_BITS-1:0]   hi_q;
    logic [N_BITS-1:0]   lo_q;
`ifdef MULDIV_DIVZERO_EN
    logic                divzero_done_q;
`endif

    logic                start_s;
    logic                is_div_s;
    logic                is_signed_s;
    logic                b_zero_s;

    logic [N_BITS:0]     mul_sum_s;
    logic [N_BITS:0]     div_rem_sh_s;
    logic                div_ge_s;
    logic [N_BITS-1:0]   div_diff_s;
    logic [N_BITS-1:0]   step_acc_d;
    logic [N_BITS-1:0]   step_lo_d;

    logic [2*N_BITS-1:0] prod_s;
    logic [2*N_BITS-1:0] prod_fix_s;
    logic [N_BITS-1:0]   quot_fix_s;
    logic [N_BITS-1:0]   rem_fix_s;
    logic [N_BITS-1:0]   fix_hi_d;
    logic [N_BITS-1:0]   fix_lo_d;

    // Request decode: the two low funct bits encode divide and unsigned.
    always_comb begin
        start_s     = i_valid & is_start(i_funct);
        is_div_s    = i_funct[1];
        is_signed_s = ~i_funct[0];
        b_zero_s    = (i_datoB == {N_BITS{1'b0}});
    end

    // One iteration of shift-add multiply or restoring divide on {acc, lo_reg}.
    always_comb begin
        mul_sum_s    = lo_reg_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
        div_rem_sh_s = {acc_q, lo_reg_q[N_BITS-1]};
        div_ge_s     = (div_rem_sh_s >= {1'b0, mcand_q});
        div_diff_s   = div_rem_sh_s[N_BITS-1:0] - mcand_q;
        if (is_div_q) begin
            step_acc_d = div_ge_s ? div_diff_s : div_rem_sh_s[N_BITS-1:0];
            step_lo_d  = {lo_reg_q[N_BITS-2:0], div_ge_s};
        end else begin
            step_acc_d = mul_sum_s[N_BITS:1];
            step_lo_d  = {mul_sum_s[0], lo_reg_q[N_BITS-1:1]};
        end
    end

    // Sign correction and HI/LO mapping applied in FIX.
    always_comb begin
        prod_s     = {acc_q, lo_reg_q};
        prod_fix_s = neg_res_q ? (~prod_s + {{(2*N_BITS-1){1'b0}}, 1'b1}) : prod_s;
        quot_fix_s = neg_res_q ? neg_n(lo_reg_q) : lo_reg_q;
        rem_fix_s  = neg_rem_q ? neg_n(acc_q) : acc_q;
        if (!is_div_q) begin
            fix_hi_d = prod_fix_s[2*N_BITS-1:N_BITS];
            fix_lo_d = prod_fix_s[N_BITS-1:0];
        end else if (divzero_q) begin
            fix_hi_d = dividend_q;
            fix_lo_d = {N_BITS{1'b1}};
        end else begin
            fix_hi_d = rem_fix_s;
            fix_lo_d = quot_fix_s;
        end
    end

    // Sequencer FSM with datapath, HI/LO and registered status outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= S_IDLE;
            count_q        <= {CNT_W{1'b0}};
            acc_q          <= {N_BITS{1'b0}};
            lo_reg_q       <= {N_BITS{1'b0}};
            mcand_q        <= {N_BITS{1'b0}};
            dividend_q     <= {N_BITS{1'b0}};
            is_div_q       <= 1'b0;
            neg_res_q      <= 1'b0;
            neg_rem_q      <= 1'b0;
            divzero_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            hi_q           <= {N_BITS{1'b0}};
            lo_q           <= {N_BITS{1'b0}};
`ifdef MULDIV_DIVZERO_EN
            divzero_done_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
                    divzero_done_q <= 1'b0;
`endif
                    if (start_s) begin
                        // Operand order is irrelevant for the product, so A always sits in the shifting register.
                        lo_reg_q   <= is_signed_s ? abs_n(i_datoA) : i_datoA;
                        mcand_q    <= is_signed_s ? abs_n(i_datoB) : i_datoB;
                        acc_q      <= {N_BITS{1'b0}};
                        dividend_q <= i_datoA;
                        is_div_q   <= is_div_s;
                        neg_res_q  <= is_signed_s & (i_datoA[N_BITS-1] ^ i_datoB[N_BITS-1]);
                        neg_rem_q  <= is_signed_s & i_datoA[N_BITS-1];
                        divzero_q  <= is_div_s & b_zero_s;
                        count_q    <= CNT_W'(N_BITS-1);
                        busy_q     <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
                        if (is_div_s && b_zero_s) begin
                            state_q        <= S_FIX;
                            done_q         <= 1'b1;
                            divzero_done_q <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                        end
`else
                        state_q <= S_RUN;
`endif
                    end else if (i_valid && (i_funct == F_MTHI)) begin
                        hi_q <= i_datoA;
                    end else if (i_valid && (i_funct == F_MTLO)) begin
                        lo_q <= i_datoA;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        acc_q    <= step_acc_d;
                        lo_reg_q <= step_lo_d;
                        if (count_q == {CNT_W{1'b0}}) begin
                            state_q <= S_FIX;
                            done_q  <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
                            divzero_done_q <= divzero_q;
`endif
                        end else begin
                            count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
                    divzero_done_q <= 1'b0;
`endif
                    if (!i_flush) begin
                        hi_q <= fix_hi_d;
                        lo_q <= fix_lo_d;
                    end else begin
                        hi_q <= hi_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline-facing combinational outputs.
    always_comb begin
        o_stall = busy_q & i_valid & is_hilo(i_funct);
        case (i_funct)
            F_MFHI:  o_result = hi_q;
            F_MFLO:  o_result = lo_q;
            default: o_result = {N_BITS{1'b0}};
        endcase
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;
`ifdef MULDIV_DIVZERO_EN
    assign o_divZero = divzero_done_q;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed test-plan cases with literal results, then randomized traffic vs an arithmetic model.
module tb_muldiv_sequencer;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
`ifdef MULDIV_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset, i_valid, i_flush;
    logic [5:0]  i_funct;
    logic [31:0] i_datoA, i_datoB;
    logic        o_busy, o_stall, o_done;
    logic [31:0] o_result, o_hi, o_lo;
`ifdef MULDIV_DIVZERO_EN
    logic        o_divZero;
`endif

    always #5 clk = ~clk;

    muldiv_sequencer #(.N_BITS(32), .N_FUNCT(6)) dut (
        .i_clock  (clk),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .i_funct  (i_funct),
        .i_datoA  (i_datoA),
        .i_datoB  (i_datoB),
        .i_flush  (i_flush),
        .o_busy   (o_busy),
        .o_stall  (o_stall),
        .o_done   (o_done),
`ifdef MULDIV_DIVZERO_EN
        .o_divZero(o_divZero),
`endif
        .o_result (o_result),
        .o_hi     (o_hi),
        .o_lo     (o_lo)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: architectural HI/LO, cycles of busy left, and the pending result.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;
    bit          m_dz;
    bit          obs_busy, obs_done, obs_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_hilo(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU) ||
               (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO);
    endfunction

    // Returns {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        logic   [63:0]   res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        if ((f == F_DIV || f == F_DIVU) && b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (f == F_MULT) begin
            sp = sa * sb;
            res = sp;
        end else if (f == F_MULTU) begin
            up = ua * ub;
            res = up;
        end else if (f == F_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            res = {sr[31:0], sq[31:0]};
        end else begin
            uq = ua / ub;
            ur = ua % ub;
            res = {ur[31:0], uq[31:0]};
        end
        return res;
    endfunction

    task automatic compare_outputs();
        bit          e_busy, e_done, e_stall;
        logic [31:0] e_res;
        e_busy  = (m_left > 0);
        e_done  = (m_left == 1);
        e_stall = e_busy && i_valid && is_hilo(i_funct);
        e_res   = (i_funct == F_MFHI) ? m_hi : ((i_funct == F_MFLO) ? m_lo : 32'd0);
        chk("busy",   {63'd0, o_busy},  {63'd0, e_busy});
        chk("done",   {63'd0, o_done},  {63'd0, e_done});
        chk("stall",  {63'd0, o_stall}, {63'd0, e_stall});
        chk("hi",     {32'd0, o_hi},    {32'd0, m_hi});
        chk("lo",     {32'd0, o_lo},    {32'd0, m_lo});
        chk("result", {32'd0, o_result},{32'd0, e_res});
`ifdef MULDIV_DIVZERO_EN
        chk("divzero", {63'd0, o_divZero}, {63'd0, (e_done && m_dz)});
`endif
    endtask

    task automatic model_edge(input logic v, input logic [5:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic fl);
        logic [63:0] r;
        bit          isdiv;
        if (m_left > 0) begin
            if (fl) begin
                m_left = 0;
            end else if (m_left == 1) begin
                m_hi   = m_phi;
                m_lo   = m_plo;
                m_left = 0;
            end else begin
                m_left = m_left - 1;
            end
        end else if (v) begin
            isdiv = (f == F_DIV) || (f == F_DIVU);
            if (f == F_MULT || f == F_MULTU || isdiv) begin
                r      = ref_op(f, a, b);
                m_phi  = r[63:32];
                m_plo  = r[31:0];
                m_dz   = isdiv && (b == 32'd0);
                m_left = (DZ_EN && m_dz) ? 1 : 33;
            end else if (f == F_MTHI) begin
                m_hi = a;
            end else if (f == F_MTLO) begin
                m_lo = a;
            end
        end
    endtask

    task automatic step(input logic v, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic fl);
        @(posedge clk);
        #1;
        i_valid = v; i_funct = f; i_datoA = a; i_datoB = b; i_flush = fl;
        #1;
        compare_outputs();
        obs_busy  = o_busy;
        obs_done  = o_done;
        obs_stall = o_stall;
        model_edge(v, f, a, b, fl);
    endtask

    // Issues one op then idles until busy drops; reports busy/done cycle counts.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int bcnt, output int dcnt);
        bit finished;
        bcnt = 0; dcnt = 0; finished = 0;
        step(1'b1, f, a, b, 1'b0);
        for (int i = 0; i < 100 && !finished; i++) begin
            step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
            if (obs_busy) bcnt++;
            if (obs_done) dcnt++;
            if (!obs_busy) finished = 1;
        end
        if (!finished) begin
            vectors++; miscompares++;
            $display("FAIL timeout: busy still high after 100 cycles");
        end
    endtask

    task automatic pick_operand(output logic [31:0] v);
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            5: v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
    endtask

    task automatic pick_funct(output logic [5:0] f);
        case ($urandom_range(0, 9))
            0: f = F_MULT;  1: f = F_MULTU; 2: f = F_DIV;  3: f = F_DIVU;
            4: f = F_MFHI;  5: f = F_MTHI;  6: f = F_MFLO; 7: f = F_MTLO;
            8: f = 6'b100000;
            default: f = F_DIV;
        endcase
    endtask

    initial begin
        int          bc, dc, sc;
        logic        rv, rfl;
        logic [5:0]  rf;
        logic [31:0] ra, rb;

        i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        i_funct = 6'd0; i_datoA = 32'd0; i_datoB = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0; m_phi = 32'd0; m_plo = 32'd0; m_left = 0; m_dz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_done", {63'd0, o_done}, 64'd0);
        chk("rst_hi",   {32'd0, o_hi},   64'd0);
        chk("rst_lo",   {32'd0, o_lo},   64'd0);
        i_reset = 1'b0;

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc);
        chk("multu_busy_len", 64'(bc), 64'd33);
        chk("multu_done_len", 64'(dc), 64'd1);
        chk("multu_hi", {32'd0, o_hi}, 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo", {32'd0, o_lo}, 64'h0000_0000_0000_0001);

        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, bc, dc);
        chk("mult_neg_hi", {32'd0, o_hi}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_neg_lo", {32'd0, o_lo}, 64'h0000_0000_FFFF_FFEB);

        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, bc, dc);
        chk("mult_min_hi", {32'd0, o_hi}, 64'h0000_0000_4000_0000);
        chk("mult_min_lo", {32'd0, o_lo}, 64'd0);

        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, bc, dc);
        chk("div_neg_lo", {32'd0, o_lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_neg_hi", {32'd0, o_hi}, 64'h0000_0000_FFFF_FFFF);

        run_op(F_DIVU, 32'd7, 32'd2, bc, dc);
        chk("divu_lo", {32'd0, o_lo}, 64'd3);
        chk("divu_hi", {32'd0, o_hi}, 64'd1);

        run_op(F_DIVU, 32'd5, 32'd0, bc, dc);
        chk("divz_lo", {32'd0, o_lo}, 64'h0000_0000_FFFF_FFFF);
        chk("divz_hi", {32'd0, o_hi}, 64'd5);
        chk("divz_busy_len", 64'(bc), DZ_EN ? 64'd1 : 64'd33);
        chk("divz_done_len", 64'(dc), 64'd1);

        step(1'b1, F_MTHI, 32'h0000_1234, 32'd0, 1'b0);
        step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        chk("mthi", {32'd0, o_hi}, 64'h0000_1234);

        // MFLO presented from cycle 5 of a MULTU is held until FIX ends.
        step(1'b1, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (4) step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        sc = 0;
        obs_busy = 1'b1;
        for (int i = 0; i < 100 && obs_busy; i++) begin
            step(1'b1, F_MFLO, 32'd0, 32'd0, 1'b0);
            if (obs_stall) sc++;
        end
        chk("mflo_stall_len", 64'(sc), 64'd29);
        chk("mflo_released",  {63'd0, o_stall}, 64'd0);
        chk("mflo_result",    {32'd0, o_result}, 64'd1);

        // Flush at cycle 10 of RUN: no completion, HI/LO untouched.
        step(1'b1, F_MULT, 32'd3, 32'd5, 1'b0);
        repeat (9) step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 6'd0, 32'd0, 32'd0, 1'b1);
        dc = 0;
        repeat (40) begin
            step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
            if (obs_done) dc++;
        end
        chk("flush_done_cnt", 64'(dc), 64'd0);
        chk("flush_busy", {63'd0, o_busy}, 64'd0);
        chk("flush_hi", {32'd0, o_hi}, 64'h0000_0000_FFFF_FFFE);
        chk("flush_lo", {32'd0, o_lo}, 64'd1);

        // Asynchronous reset at cycle 10 of RUN.
        step(1'b1, F_MULTU, 32'd3, 32'd5, 1'b0);
        repeat (9) step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
        #1;
        chk("arst_busy", {63'd0, o_busy}, 64'd0);
        chk("arst_done", {63'd0, o_done}, 64'd0);
        chk("arst_hi",   {32'd0, o_hi},   64'd0);
        chk("arst_lo",   {32'd0, o_lo},   64'd0);
        m_left = 0; m_hi = 32'd0; m_lo = 32'd0;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        repeat (40) step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);

        // Randomized traffic, including stalled requests and occasional flushes.
        for (int n = 0; n < 6000; n++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rfl = ($urandom_range(0, 63) == 0);
            pick_funct(rf);
            pick_operand(ra);
            pick_operand(rb);
            step(rv, rf, ra, rb, rfl);
        end
        repeat (40) step(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
